// File: rtl/r2rv_pkg.sv
// Shared types for the r2rv out-of-order core: buffer entries, execution units,
// load/store modes and the commit FSM state.
package r2rv_pkg;

    localparam int unsigned BUF_SIZE_LOG = 4;

    typedef logic bool;
    typedef logic [BUF_SIZE_LOG-1:0] tag_t;

    typedef enum logic [1:0] {S_NOT_USED, S_QUEUED, S_EXECUTING, S_EXECUTED} state_t;
    typedef enum logic [2:0] {ALU, MUL, LOAD, STORE, BRANCH} unit_t;
    typedef enum logic [1:0] {BYTE, HALF, WORD} ldst_mode_t;
    typedef enum logic {C_IDLE, C_STORE_WAIT} commit_state_t;

    typedef struct packed {
        state_t      e_state;
        logic [5:0]  speculative_tag;
        unit_t       Unit;
        logic [4:0]  Dest;
        logic [31:0] result;
        tag_t        tag;
        logic [31:0] A;
        logic [31:0] Vk;
        ldst_mode_t  rwmm;
    } entry_t;

    // Executed and no longer under any unresolved branch.
    function automatic bool slot_ready(entry_t e);
        return (e.e_state == S_EXECUTED) && (e.speculative_tag == '0);
    endfunction

endpackage

// File: rtl/commit_store_port.sv
// Store handshake for the commit stage: latches the head store, holds the request
// stable until st_ack, and flags the acknowledge cycle so the store can commit.
module commit_store_port
    import r2rv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [31:0]   addr,
    input  logic [31:0]   data,
    input  ldst_mode_t    mode,
    input  logic          st_ack,
    output commit_state_t state,
    output logic          ack_commit,
    output logic          st_req,
    output logic [31:0]   st_addr,
    output logic [31:0]   st_data,
    output ldst_mode_t    st_mode
);

    commit_state_t state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= C_IDLE;
            st_req  <= 1'b0;
            st_addr <= '0;
            st_data <= '0;
            st_mode <= BYTE;
        end else begin
            unique case (state_q)
                C_IDLE: begin
                    if (start) begin
                        state_q <= C_STORE_WAIT;
                        st_req  <= 1'b1;
                        st_addr <= addr;
                        st_data <= data;
                        st_mode <= mode;
                    end
                end
                C_STORE_WAIT: begin
                    // Address/data/mode stay latched; only the request drops.
                    if (st_ack) begin
                        state_q <= C_IDLE;
                        st_req  <= 1'b0;
                    end
                end
                default: state_q <= C_IDLE;
            endcase
        end
    end

    assign state      = state_q;
    assign ack_commit = (state_q == C_STORE_WAIT) && st_ack;

endmodule

// File: rtl/commit_unit.sv
// In-order commit of up to two head entries per cycle, with stores serialised through
// commit_store_port. Performance counters are built only with COMMIT_PERF_CNT_EN.
module commit_unit
    import r2rv_pkg::*;
#(
    parameter int unsigned BUF_SIZE_LOG = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  entry_t [1:0]     head,
    output bool    [1:0]     is_really_commited,
    output bool    [1:0]     is_commited_store,
    output logic   [1:0]     rf_we,
    output logic   [1:0][4:0]  rf_waddr,
    output logic   [1:0][31:0] rf_wdata,
    output tag_t   [1:0]     rf_wtag,
    output logic             st_req,
    output logic   [31:0]    st_addr,
    output logic   [31:0]    st_data,
    output ldst_mode_t       st_mode,
    input  logic             st_ack,
    output logic   [31:0]    commit_count,
    output logic   [31:0]    store_stall_cycles
);

    commit_state_t                   state;
    logic                            store_ack;
    logic                            store_start;
    logic [1:0][BUF_SIZE_LOG-1:0]    slot_tag;

    assign store_start = (state == C_IDLE) && slot_ready(head[0]) && (head[0].Unit == STORE);

    commit_store_port u_store_port (
        .clk       (clk),
        .reset     (reset),
        .start     (store_start),
        .addr      (head[0].A),
        .data      (head[0].Vk),
        .mode      (head[0].rwmm),
        .st_ack    (st_ack),
        .state     (state),
        .ack_commit(store_ack),
        .st_req    (st_req),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_mode   (st_mode)
    );

    always_comb begin
        is_really_commited = '0;
        is_commited_store  = '0;
        rf_we              = '0;
        rf_waddr           = '0;
        rf_wdata           = '0;
        slot_tag           = '0;

        is_really_commited[0] = reset && (store_ack ||
            ((state == C_IDLE) && slot_ready(head[0]) && (head[0].Unit != STORE)));
        is_commited_store[0]  = reset && store_ack;
        // Slot 1 only rides along with a non-store slot 0.
        is_really_commited[1] = is_really_commited[0] && (head[0].Unit != STORE) &&
                                slot_ready(head[1]) && (head[1].Unit != STORE);

        for (int k = 0; k < 2; k++) begin
            rf_we[k] = is_really_commited[k] && (head[k].Unit != STORE) && (head[k].Dest != '0);
            if (reset) begin
                rf_waddr[k] = head[k].Dest;
                rf_wdata[k] = head[k].result;
                slot_tag[k] = head[k].tag;
            end
        end
    end

    assign rf_wtag[0] = tag_t'(slot_tag[0]);
    assign rf_wtag[1] = tag_t'(slot_tag[1]);

    logic unused_slot1;
    assign unused_slot1 = ^{head[1].A, head[1].Vk, head[1].rwmm};

`ifdef COMMIT_PERF_CNT_EN
    logic [31:0] commit_count_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commit_count_q <= '0;
            stall_q        <= '0;
        end else begin
            commit_count_q <= commit_count_q + 32'(is_really_commited[0])
                                             + 32'(is_really_commited[1]);
            stall_q        <= stall_q + 32'((state == C_STORE_WAIT) && !st_ack);
        end
    end

    assign commit_count       = commit_count_q;
    assign store_stall_cycles = stall_q;
`else
    assign commit_count       = '0;
    assign store_stall_cycles = '0;
`endif

endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 The block SHALL take parameter BUF_SIZE_LOG, default 4, as log2 of buffer depth; only head slots 0 and 1 are read.
REQ-002 The block SHALL have port clk, input, 1 bit, single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port head, input, 2 x entry_t; entries[0] (oldest) and entries[1] of the instruction buffer.
REQ-005 The block SHALL have ports is_really_commited and is_commited_store, output, 2 x bool; the commit indication returned to the buffer.
REQ-006 The block SHALL have ports rf_we, output, 2 x 1; rf_waddr, output, 2 x 5; rf_wdata, output, 2 x 32; and rf_wtag, output, 2 x tag_t; these form the register-file and rename-table write port.
REQ-007 The block SHALL have ports st_req, output, 1; st_addr, output, 32; st_data, output, 32; st_mode, output, ldst_mode_t; and st_ack, input, 1; these form the data-memory store handshake.
REQ-008 The block SHALL have ports commit_count and store_stall_cycles, output, 32 each; these are performance counters.

Function
REQ-009 A slot SHALL be ready when e_state==S_EXECUTED and speculative_tag==0.
REQ-010 FSM states SHALL be C_IDLE and C_STORE_WAIT, held in a register; commit outputs are combinational from the FSM state, head, and st_ack.
REQ-011 In C_IDLE with slot 0 ready and Unit!=STORE, the block SHALL assert is_really_commited[0] in the same cycle.
REQ-012 In C_IDLE with slot 0 ready and Unit==STORE, the block SHALL commit nothing, register st_req=1 with st_addr=A, st_data=Vk and st_mode=rwmm, and enter C_STORE_WAIT.
REQ-013 In C_STORE_WAIT, st_req, st_addr, st_data and st_mode SHALL stay stable until st_ack is sampled high.
REQ-014 On the st_ack cycle, the block SHALL assert is_really_commited[0]=is_commited_store[0]=true; next cycle st_req=0 and the state is C_IDLE.
REQ-015 The block SHALL assert is_really_commited[1] only if is_really_commited[0] is asserted, slot 0 is not a store, and slot 1 is ready and not a store.
REQ-016 is_really_commited[1] SHALL never be true while is_really_commited[0] is false.
REQ-017 rf_we[k] SHALL equal is_really_commited[k] AND Unit!=STORE AND Dest!=0, with rf_waddr=Dest, rf_wdata=result and rf_wtag=tag.
REQ-018 If both slots write the same Dest in one cycle, both writes SHALL be presented; the consumer gives slot 1 priority.
REQ-019 Slot 0 not ready SHALL give zero commits; an empty buffer (e_state==S_NOT_USED) is not ready.
REQ-020 An st_ack in C_IDLE SHALL be ignored.
REQ-021 The block SHALL issue a new st_req no earlier than one cycle after the previous acknowledgement.
REQ-022 commit_count SHALL add the number of commits each cycle (0, 1 or 2), wrapping at 2^32.
REQ-023 store_stall_cycles SHALL increment on each C_STORE_WAIT cycle without st_ack, wrapping at 2^32.

Reset
REQ-024 Asserting reset SHALL immediately force state C_IDLE, st_req=0, st_addr=0, st_data=0, st_mode=BYTE and both counters to 0.
REQ-025 Reset during C_STORE_WAIT SHALL abandon the store without a commit, and an st_ack arriving after reset is ignored.
REQ-026 While reset is asserted, combinational commit and rf outputs SHALL be false or 0.

Configuration
REQ-027 Macro COMMIT_PERF_CNT_EN defined SHALL implement the REQ-022/023 counters; undefined, the ports remain and are tied to 0 with no counter flops.

Structure
REQ-028 entry_t, state_t, unit_t, ldst_mode_t, bool, tag_t, BUF_SIZE_LOG and the new commit_state_t SHALL reside in the shared package r2rv_pkg.
REQ-029 The store FSM and registered store outputs SHALL form the sub-module commit_store_port; commit_unit holds the slot logic and counters.

Verification
REQ-030 Slot0 ALU executed, Dest=5, result=0x1234; slot1 MUL executed, Dest=6 -> both commits and rf_we=11 in the same cycle, commit_count +2.
REQ-031 Slot0 STORE executed, A=0x100, Vk=0xAB, rwmm=WORD; st_ack after 3 wait cycles -> st_req high for 4 cycles with stable outputs, commit[0] plus is_commited_store[0] only on the ack cycle, store_stall_cycles=3.
REQ-032 Slot0 executed with speculative_tag=6'b000010 -> no commit; clearing the tag to 0 -> commit next evaluation.
REQ-033 Slot0 ALU, Dest=0 -> commit with rf_we[0]=0; slot0 not executed and slot1 executed -> zero commits.
REQ-034 Reset asserted in C_STORE_WAIT, then st_ack=1 after release -> st_req=0 at once, no store commit, state C_IDLE.
REQ-035 Build without COMMIT_PERF_CNT_EN and commit 10 instructions -> both counters read 0.
